// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults and index helpers for the scoreboarded register file.
package reg_file_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int NUM_REGS_DEF = 8;
  localparam int SEL_W_DEF = $clog2(NUM_REGS_DEF);
  function automatic logic in_range(input int idx, input int n);
    return idx < n;
  endfunction
endpackage

// File: rtl/decoder_onehot.sv
// decoder_onehot: enabled one-hot decoder; indices at or beyond N decode to all zeros.
module decoder_onehot #(
  parameter int SEL_W = 3,
  parameter int NUM_REGS = 8
) (
  input  logic                en,
  input  logic [SEL_W-1:0]    sel,
  output logic [NUM_REGS-1:0] y
);
  assign y = (en && int'(sel) < NUM_REGS) ? NUM_REGS'(1) << sel : '0;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with pending-result scoreboard and optional write-to-read bypass.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int BYPASS = 1,
  localparam int SEL_W = $clog2(NUM_REGS)
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                LD_REG,
  input  logic [SEL_W-1:0]    DR,
  input  logic [WIDTH-1:0]    D_in,
  input  logic [SEL_W-1:0]    SR1,
  input  logic [SEL_W-1:0]    SR2,
  output logic [WIDTH-1:0]    SR1_out,
  output logic [WIDTH-1:0]    SR2_out,
  input  logic                Issue,
  input  logic [SEL_W-1:0]    Issue_DR,
  output logic                Pend_SR1,
  output logic                Pend_SR2,
  output logic                Busy_any,
  output logic [NUM_REGS-1:0] Ld_signals
);
  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] iss;
  logic                sr1_ok, sr2_ok, byp1, byp2;
  decoder_onehot #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_ld (.en(LD_REG), .sel(DR), .y(Ld_signals));
  decoder_onehot #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_iss (.en(Issue), .sel(Issue_DR), .y(iss));
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) regs <= '{default: '0};
    else
      for (int i = 0; i < NUM_REGS; i++)
        if (Ld_signals[i]) regs[i] <= D_in;
  end
  // set is ORed in after the clear so a same-index issue wins over a write
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) pending <= '0;
    else pending <= (pending & ~Ld_signals) | iss;
  end
  // reads are held at zero during reset so a bypassed D_in cannot leak out
  always_comb begin
    sr1_ok = Reset && in_range(int'(SR1), NUM_REGS);
    sr2_ok = Reset && in_range(int'(SR2), NUM_REGS);
    byp1 = BYPASS != 0 && sr1_ok && Ld_signals[SR1];
    byp2 = BYPASS != 0 && sr2_ok && Ld_signals[SR2];
    SR1_out = !sr1_ok ? '0 : byp1 ? D_in : regs[SR1];
    SR2_out = !sr2_ok ? '0 : byp2 ? D_in : regs[SR2];
    Pend_SR1 = sr1_ok && pending[SR1] && !byp1;
    Pend_SR2 = sr2_ok && pending[SR2] && !byp2;
    Busy_any = |pending;
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed scoreboard bench over bypass, no-bypass and six-register instances.
module tb_reg_file_sb;
  logic        Clk = 0, Reset = 0, LD_REG = 0, Issue = 0;
  logic [2:0]  DR = 0, SR1 = 0, SR2 = 0, Issue_DR = 0;
  logic [15:0] D_in = 0;
  logic [15:0] a_sr1, a_sr2, b_sr1, b_sr2, c_sr1, c_sr2;
  logic        a_p1, a_p2, a_busy, b_p1, b_p2, b_busy, c_p1, c_p2, c_busy;
  logic [7:0]  a_ld, b_ld;
  logic [5:0]  c_ld;
  int          total = 0, passed = 0;
  typedef struct {string tag; logic [31:0] v;} exp_t;
  exp_t        sb[$];
  always #5 Clk = ~Clk;
  reg_file_sb dut_a (.Clk(Clk), .Reset(Reset), .LD_REG(LD_REG), .DR(DR), .D_in(D_in), .SR1(SR1), .SR2(SR2),
    .SR1_out(a_sr1), .SR2_out(a_sr2), .Issue(Issue), .Issue_DR(Issue_DR), .Pend_SR1(a_p1), .Pend_SR2(a_p2),
    .Busy_any(a_busy), .Ld_signals(a_ld));
  reg_file_sb #(.BYPASS(0)) dut_b (.Clk(Clk), .Reset(Reset), .LD_REG(LD_REG), .DR(DR), .D_in(D_in), .SR1(SR1), .SR2(SR2),
    .SR1_out(b_sr1), .SR2_out(b_sr2), .Issue(Issue), .Issue_DR(Issue_DR), .Pend_SR1(b_p1), .Pend_SR2(b_p2),
    .Busy_any(b_busy), .Ld_signals(b_ld));
  reg_file_sb #(.NUM_REGS(6)) dut_c (.Clk(Clk), .Reset(Reset), .LD_REG(LD_REG), .DR(DR), .D_in(D_in), .SR1(SR1), .SR2(SR2),
    .SR1_out(c_sr1), .SR2_out(c_sr2), .Issue(Issue), .Issue_DR(Issue_DR), .Pend_SR1(c_p1), .Pend_SR2(c_p2),
    .Busy_any(c_busy), .Ld_signals(c_ld));
  task automatic expect_v(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask
  task automatic chk(input logic [31:0] obs);
    exp_t e;
    e = sb.pop_front();
    total++;
    assert (obs === e.v) passed++;
    else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
  endtask
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  initial begin
    #2;
    LD_REG = 1; DR = 3; D_in = 16'h5555; SR1 = 3;
    expect_v("rst_ld", 32'h08); expect_v("rst_sr1", 0); expect_v("rst_busy", 0); expect_v("rst_p1", 0);
    #1;
    chk(32'(a_ld)); chk(32'(a_sr1)); chk(32'(a_busy)); chk(32'(a_p1));
    LD_REG = 0;
    @(negedge Clk);
    Reset = 1;
    tick();
    LD_REG = 1; DR = 3; D_in = 16'hBEEF; SR1 = 0;
    expect_v("wr_ld", 32'h08);
    #1 chk(32'(a_ld));
    tick();
    LD_REG = 0; SR1 = 3;
    expect_v("rd_a", 32'hBEEF); expect_v("rd_b", 32'hBEEF);
    #1 chk(32'(a_sr1)); chk(32'(b_sr1));
    LD_REG = 1; DR = 5; D_in = 16'h1234; SR2 = 5;
    expect_v("byp_a", 32'h1234); expect_v("nobyp_b", 32'h0000);
    #1 chk(32'(a_sr2)); chk(32'(b_sr2));
    tick();
    LD_REG = 0;
    expect_v("nobyp_b_next", 32'h1234);
    #1 chk(32'(b_sr2));
    Issue = 1; Issue_DR = 2;
    tick();
    Issue = 0; SR1 = 2;
    expect_v("pend_set", 1); expect_v("busy_set", 1);
    #1 chk(32'(a_p1)); chk(32'(a_busy));
    LD_REG = 1; DR = 2; D_in = 16'h0007;
    expect_v("pend_byp_a", 0); expect_v("pend_nobyp_b", 1); expect_v("busy_nobyp", 1);
    #1 chk(32'(a_p1)); chk(32'(b_p1)); chk(32'(a_busy));
    tick();
    LD_REG = 0;
    expect_v("pend_clr", 0); expect_v("busy_clr", 0);
    #1 chk(32'(a_p1)); chk(32'(a_busy));
    Issue = 1; Issue_DR = 6; LD_REG = 1; DR = 6; D_in = 16'hABCD;
    tick();
    Issue = 0; LD_REG = 0; SR1 = 6;
    expect_v("set_wins", 1); expect_v("r6_data", 32'hABCD);
    #1 chk(32'(a_p1)); chk(32'(a_sr1));
    Issue = 1; Issue_DR = 6;
    tick();
    Issue = 0;
    expect_v("reissue", 1);
    #1 chk(32'(a_p1));
    LD_REG = 1; DR = 7; D_in = 16'hFFFF;
    expect_v("oor_ld", 0);
    #1 chk(32'(c_ld));
    tick();
    LD_REG = 0; SR1 = 7; SR2 = 5;
    expect_v("oor_rd", 0); expect_v("oor_pend", 0); expect_v("oor_nochg", 32'h1234);
    #1 chk(32'(c_sr1)); chk(32'(c_p1)); chk(32'(c_sr2));
    Issue = 1; Issue_DR = 7;
    tick();
    Issue = 0;
    expect_v("oor_issue", 0);
    #1 chk(32'(c_busy));
    LD_REG = 1; DR = 1; D_in = 16'h1111;
    tick();
    DR = 4; D_in = 16'h4444; Issue = 1; Issue_DR = 1;
    tick();
    LD_REG = 0; Issue_DR = 4;
    tick();
    Issue = 0; SR1 = 1; SR2 = 4;
    expect_v("pre_r1", 32'h1111); expect_v("pre_p1", 1); expect_v("pre_p2", 1);
    #1 chk(32'(a_sr1)); chk(32'(a_p1)); chk(32'(a_p2));
    #1 Reset = 0;
    expect_v("arst_sr1", 0); expect_v("arst_sr2", 0); expect_v("arst_p1", 0);
    expect_v("arst_p2", 0); expect_v("arst_busy", 0);
    #1 chk(32'(a_sr1)); chk(32'(a_sr2)); chk(32'(a_p1)); chk(32'(a_p2)); chk(32'(a_busy));
    @(negedge Clk);
    Reset = 1;
    tick();
    expect_v("post_sr1", 0); expect_v("post_sr2", 0); expect_v("post_busy", 0);
    #1 chk(32'(a_sr1)); chk(32'(a_sr2)); chk(32'(a_busy));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
